// File: rtl/fft_frame_sequencer.sv
// Streams NUM_FRAMES overlapping FRAME_LEN frames from the sample buffer into the FFT.
// Optional macro FFT_SEQ_ZERO_PAD_EN: zero-pad past len instead of wrapping the address.
module fft_frame_sequencer #(
  parameter int FRAME_LEN  = 2048,
  parameter int NUM_FRAMES = 4,
  parameter int ADDR_W     = 17,
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in_n,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] length_in,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [7:0]        rd_data_in,
  output logic [31:0]       m_tdata_out,
  output logic              m_tvalid_out,
  output logic              m_tlast_out,
  input  logic              m_tready_in,
  input  logic              frame_ack_in,
  output logic [FW-1:0]     frame_idx_out,
  output logic              busy_out,
  output logic              done_out
);

  localparam int LOG_NF = $clog2(NUM_FRAMES);
  localparam int NW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [NW-1:0] LAST_N = NW'(FRAME_LEN - 1);
  localparam logic [FW-1:0] LAST_K = FW'(NUM_FRAMES - 1);
  localparam logic [NW-1:0] N_ONE = 1;
  localparam logic [FW-1:0] K_ONE = 1;
  localparam logic [ADDR_W:0] A_ONE = 1;

  typedef enum logic [1:0] {
    IDLE, PREFETCH, STREAM, WAIT_ACK
  } state_t;

  state_t state_q, state_d;
  logic start_q, start_d;
  logic done_q, done_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] hop_q, hop_d;
  logic [ADDR_W:0] base_q, base_d;
  logic [ADDR_W:0] a_q, a_d;
  logic [NW-1:0] n_q, n_d;
  logic [FW-1:0] k_q, k_d;

  logic [ADDR_W:0] len_x, a_inc, a_nxt, rd_x, rd_c;
  logic accept, adv, pad;
  logic unused_rd_msb;

  // Address datapath; BRAM sees the address of the sample shown next cycle.
  always_comb begin
    len_x  = {1'b0, len_q};
    a_inc  = a_q + A_ONE;
    accept = (state_q == STREAM) && m_tready_in;
    adv    = accept && (n_q != LAST_N);
`ifdef FFT_SEQ_ZERO_PAD_EN
    a_nxt = a_inc;
    pad   = (a_q >= len_x);
`else
    a_nxt = (a_inc >= len_x) ? '0 : a_inc;
    pad   = 1'b0;
`endif
    if (state_q == PREFETCH) rd_x = base_q;
    else if (adv)            rd_x = a_nxt;
    else                     rd_x = a_q;
`ifdef FFT_SEQ_ZERO_PAD_EN
    rd_c = (rd_x >= len_x) ? (len_x - A_ONE) : rd_x;
`else
    rd_c = rd_x;
`endif
  end

  assign unused_rd_msb = rd_c[ADDR_W];
  assign rd_addr_out   = (state_q == IDLE) ? '0 : rd_c[ADDR_W-1:0];
  assign m_tvalid_out  = (state_q == STREAM);
  assign m_tlast_out   = m_tvalid_out && (n_q == LAST_N);
  assign m_tdata_out   = (m_tvalid_out && !pad) ?
                         {16'h0, rd_data_in, 8'h00} : '0;
  assign frame_idx_out = k_q;
  assign busy_out      = (state_q != IDLE);
  assign done_out      = done_q;

  // Sequencer next-state: start latch, frame walk, beat count.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    len_d   = len_q;
    hop_d   = hop_q;
    base_d  = base_q;
    a_d     = a_q;
    n_d     = n_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d = PREFETCH;
          k_d     = '0;
          base_d  = '0;
        end else if (start_in) begin
          if (length_in != '0) begin
            start_d = 1'b1;
            len_d   = length_in;
            hop_d   = length_in >> LOG_NF;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      PREFETCH: begin
        a_d     = base_q;
        n_d     = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (accept) begin
          if (n_q == LAST_N) begin
            state_d = WAIT_ACK;
          end else begin
            n_d = n_q + N_ONE;
            a_d = a_nxt;
          end
        end
      end
      WAIT_ACK: begin
        if (frame_ack_in) begin
          if (k_q == LAST_K) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            k_d     = k_q + K_ONE;
            base_d  = base_q + {1'b0, hop_q};
            state_d = PREFETCH;
          end
        end
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      len_q   <= '0;
      hop_q   <= '0;
      base_q  <= '0;
      a_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      done_q  <= done_d;
      len_q   <= len_d;
      hop_q   <= hop_d;
      base_q  <= base_d;
      a_q     <= a_d;
      n_q     <= n_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer (FRAME_LEN 16, NUM_FRAMES 4).
// Works in both builds; tail expectations follow FFT_SEQ_ZERO_PAD_EN.
module tb_fft_frame_sequencer;

  localparam int FL = 16;
  localparam int NF = 4;
  localparam int AW = 17;

  logic clk, rst_n, start, rdy, ack;
  logic [AW-1:0] length, rd_addr;
  logic [7:0] rd_data;
  logic [31:0] tdata;
  logic tvalid, tlast, busy, done;
  logic [1:0] fidx;

  logic [7:0] mem [256];

  typedef struct {
    int k;
    bit last;
    logic [31:0] data;
  } beat_t;

  beat_t sbq[$];
  int checks = 0;
  int failures = 0;

  fft_frame_sequencer #(
    .FRAME_LEN(FL), .NUM_FRAMES(NF), .ADDR_W(AW)
  ) dut (
    .clk_in(clk), .rst_in_n(rst_n),
    .start_in(start), .length_in(length),
    .rd_addr_out(rd_addr), .rd_data_in(rd_data),
    .m_tdata_out(tdata), .m_tvalid_out(tvalid),
    .m_tlast_out(tlast), .m_tready_in(rdy),
    .frame_ack_in(ack), .frame_idx_out(fidx),
    .busy_out(busy), .done_out(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr[7:0]];

  function automatic logic [31:0] exp_data(int len, int k, int n);
    int a;
    a = k * (len >> 2) + n;
`ifdef FFT_SEQ_ZERO_PAD_EN
    if (a >= len) return 32'h0;
`else
    a = a % len;
`endif
    return {16'h0, mem[a], 8'h00};
  endfunction

  task automatic run_seq(input int len, input bit rnd, input int ack_dly,
                         input bit early, input bit bstart);
    int beats, dones, nfr, wcnt, cyc;
    bit got_done, pstall, injected;
    logic [31:0] pd;
    logic pl;
    logic [AW-1:0] pa;
    beat_t e;
    beats = 0; dones = 0; nfr = 0; wcnt = -1; cyc = 0;
    got_done = 0; pstall = 0; injected = 0;
    pd = '0; pl = 0; pa = '0;
    sbq.delete();
    for (int k = 0; k < NF; k++)
      for (int n = 0; n < FL; n++) begin
        e.k = k; e.last = (n == FL - 1); e.data = exp_data(len, k, n);
        sbq.push_back(e);
      end
    @(posedge clk); #1;
    start = 1; length = AW'(len); rdy = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tvalid !== 1'b0) begin
      failures++;
      $display("FAIL lat_t0 len=%0d busy=%b valid=%b exp 0 0", len, busy, tvalid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tvalid !== 1'b0 || rd_addr !== '0) begin
      failures++;
      $display("FAIL lat_t1 len=%0d busy=%b valid=%b addr=%0d exp 1 0 0",
               len, busy, tvalid, rd_addr);
    end
    while (!got_done && cyc < 3000) begin
      @(posedge clk); #1;
      ack = 0; start = 0;
      if (wcnt > 0) wcnt--;
      if (wcnt == 0) begin ack = 1; wcnt = -1; end
      if (early && nfr == 5 && !ack) ack = 1;
      if (bstart && beats == 20 && !injected) begin
        start = 1; length = AW'(8); injected = 1;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
      if (pstall) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl ||
            (!rdy && rd_addr !== pa)) begin
          failures++;
          $display("FAIL stall v=%b d=%h l=%b a=%0d exp 1 %h %b %0d",
                   tvalid, tdata, tlast, rd_addr, pd, pl, pa);
        end
      end
`ifdef FFT_SEQ_ZERO_PAD_EN
      if (tvalid) begin
        checks++;
        if (rd_addr >= AW'(len)) begin
          failures++;
          $display("FAIL pad_addr addr=%0d exp <%0d", rd_addr, len);
        end
      end
`endif
      if (tvalid && rdy) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL extra_beat d=%h exp none", tdata);
        end else begin
          e = sbq.pop_front();
          if (tdata !== e.data || tlast !== e.last || fidx !== 2'(e.k)) begin
            failures++;
            $display("FAIL beat len=%0d n=%0d d=%h l=%b k=%0d exp %h %b %0d",
                     len, beats, tdata, tlast, fidx, e.data, e.last, e.k);
          end
        end
        beats++; nfr++;
        if (tlast) begin nfr = 0; wcnt = ack_dly; end
      end
      pstall = tvalid && !rdy;
      pd = tdata; pl = tlast; pa = rd_addr;
      if (done) begin
        dones++; got_done = 1;
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL busy_at_done busy=%b exp 0", busy);
        end
      end
    end
    ack = 0; start = 0;
    if (!got_done) begin
      failures++;
      $display("FAIL timeout len=%0d beats=%0d exp done", len, beats);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 1 || beats != NF * FL || sbq.size() != 0) begin
      failures++;
      $display("FAIL seq_end len=%0d dones=%0d beats=%0d left=%0d exp 1 %0d 0",
               len, dones, beats, sbq.size(), NF * FL);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; length = '0; rdy = 0; ack = 0;
    #12;
    checks++;
    if (rd_addr !== '0 || tdata !== '0 || tvalid !== 0 || tlast !== 0 ||
        fidx !== '0 || busy !== 0 || done !== 0) begin
      failures++;
      $display("FAIL reset a=%0d d=%h v=%b l=%b k=%0d b=%b dn=%b exp all 0",
               rd_addr, tdata, tvalid, tlast, fidx, busy, done);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic();
    run_seq(64, 0, 3, 0, 0);
  endtask

  task automatic test_backpressure();
    run_seq(64, 1, 2, 0, 0);
  endtask

  task automatic test_tail();
    run_seq(40, 0, 3, 0, 0);
  endtask

  task automatic test_len3();
    run_seq(3, 0, 1, 0, 0);
  endtask

  task automatic test_ignored();
    run_seq(64, 0, 4, 1, 1);
  endtask

  task automatic test_len0();
    bit rose;
    rose = 0;
    @(posedge clk); #1;
    start = 1; length = '0;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL len0_done dn=%b v=%b b=%b exp 1 0 0", done, tvalid, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL len0_pulse dn=%b exp 0", done);
    end
    repeat (6) begin
      @(negedge clk);
      if (tvalid) rose = 1;
    end
    checks++;
    if (rose) begin
      failures++;
      $display("FAIL len0_valid rose=1 exp 0");
    end
  endtask

  task automatic test_reset_mid();
    int cnt, cyc;
    bit wt, hit;
    cnt = 0; cyc = 0; wt = 0; hit = 0;
    @(posedge clk); #1;
    start = 1; length = AW'(64); rdy = 1;
    @(posedge clk); #1;
    start = 0;
    while (!hit && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (tvalid && cnt == FL + 7) begin
        hit = 1;
      end else begin
        if (tvalid && rdy) cnt++;
        wt = !tvalid && busy;
        @(posedge clk); #1;
        ack = wt;
      end
    end
    ack = 0;
    checks++;
    if (!hit || fidx !== 2'd1) begin
      failures++;
      $display("FAIL rstmid_reach hit=%b k=%0d exp 1 1", hit, fidx);
    end
    rst_n = 0;
    #1;
    checks++;
    if (rd_addr !== '0 || tdata !== '0 || tvalid !== 0 || tlast !== 0 ||
        fidx !== '0 || busy !== 0 || done !== 0) begin
      failures++;
      $display("FAIL rstmid a=%0d d=%h v=%b l=%b k=%0d b=%b dn=%b exp all 0",
               rd_addr, tdata, tvalid, tlast, fidx, busy, done);
    end
    @(negedge clk);
    rst_n = 1;
    run_seq(64, 0, 1, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    test_reset();
    test_basic();
    test_backpressure();
    test_tail();
    test_len0();
    test_len3();
    test_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Sequences recorded audio into the FFT core. After the recorder signals that a recording is finished, it reads the sample buffer and streams NUM_FRAMES overlapping-hop frames of FRAME_LEN samples into the FFT's AXI-Stream slave. It asserts tlast on each frame's final sample and waits for the tone-detection FSM to acknowledge each frame before starting the next. It sits between the recorder BRAM, xfft, and tone_detection_fsm, and replaces ad-hoc frame counting in the top level.

## Interface
- FRAME_LEN, 2048: samples per FFT frame; power of 2.
- NUM_FRAMES, 4: frames per recording; power of 2, at least 1.
- ADDR_W, 17: sample-buffer address width.

- clk_in  in  1  system clock, 100 MHz.
- rst_in_n  in  1  asynchronous, active-low reset.
- start_in  in  1  one-cycle pulse: recording finished.
- length_in  in  ADDR_W  recorded sample count; sampled on start_in.
- rd_addr_out  out  ADDR_W  sample-buffer read address.
- rd_data_in  in  8  signed sample; valid one cycle after rd_addr_out.
- m_tdata_out  out  32  [15:0] = {sample, 8'b0} (real); [31:16] = 0 (imaginary).
- m_tvalid_out  out  1  AXI-Stream valid to the FFT.
- m_tlast_out  out  1  last sample of the frame.
- m_tready_in  in  1  FFT ready.
- frame_ack_in  in  1  one-cycle pulse: downstream has consumed the frame result.
- frame_idx_out  out  log2(NUM_FRAMES), minimum 1  index of the current frame.
- busy_out  out  1  sequence in progress.
- done_out  out  1  one-cycle pulse: all frames acknowledged.

## Operation
- States:
  - IDLE → (start_in && length_in != 0) → PREFETCH.
  - start_in with length_in == 0 → done_out pulses the next cycle; state remains IDLE.
- On start:
  - latch len = length_in.
  - hop = len >> log2(NUM_FRAMES).
  - frame k starts at base_k = k*hop; k runs 0..NUM_FRAMES-1.
- PREFETCH (1 cycle): drive rd_addr_out = base_k, then go to STREAM.
- STREAM:
  - Sample n of the frame is read from address base_k+n, for n = 0..FRAME_LEN-1.
  - The output register holds one sample. While m_tvalid_out && !m_tready_in, rd_addr_out and all outputs stay frozen.
  - A sample is accepted on m_tvalid_out && m_tready_in. On acceptance the next sample is presented the following cycle, so throughput is 1 sample per cycle.
  - m_tlast_out = 1 only for n == FRAME_LEN-1.
  - Acceptance of the tlast sample → WAIT_ACK.
- WAIT_ACK:
  - m_tvalid_out = 0.
  - On frame_ack_in: if k < NUM_FRAMES-1, increment k → PREFETCH. Otherwise → IDLE and pulse done_out.
- Reads past the end (base_k+n ≥ len) follow the Configuration section.
- Address arithmetic is done at ADDR_W+1 bits to avoid wrap-around before the ≥ len compare.
- start_in while busy_out: ignored.
- frame_ack_in outside WAIT_ACK: ignored.
- frame_ack_in arriving in the same cycle as the tlast acceptance: ignored; WAIT_ACK always lasts at least 1 cycle.
- len < NUM_FRAMES: hop = 0, so every frame starts at address 0.

## Timing
- Reset values (asynchronous): state IDLE; rd_addr_out 0; m_tdata_out 0; m_tvalid_out 0; m_tlast_out 0; frame_idx_out 0; busy_out 0; done_out 0.
- Deassertion of rst_in_n takes effect synchronously with clk_in.
- Reset mid-frame aborts immediately. No tlast is emitted for the aborted frame.
- start_in at edge t:
  - busy_out = 1 and rd_addr_out = base_0 after edge t+1.
  - m_tvalid_out = 1 with sample 0 after edge t+2.
- Frame duration with m_tready_in held high: FRAME_LEN cycles from first valid to tlast acceptance.
- AXI rule: once asserted, m_tvalid_out stays high and m_tdata_out/m_tlast_out stay stable until acceptance.
- busy_out is high from PREFETCH through WAIT_ACK. It falls in the same cycle done_out pulses.
- frame_idx_out updates when entering PREFETCH.

## Configuration
- FFT_SEQ_ZERO_PAD_EN:
  - Defined: samples at addresses ≥ len are presented as m_tdata_out = 0. rd_addr_out is not advanced past len-1, so no out-of-range read is issued.
  - Undefined: the address wraps modulo len (wraps to 0 after len-1). Data always comes from rd_data_in.
  - Handshake, tlast, and latency are identical in both builds.

## Test plan
- Basic sequence (FRAME_LEN 16, NUM_FRAMES 4, len 64, tready high, ack 3 cycles after each tlast): frame starts at addresses 0/16/32/48; 16 beats each; tlast on beat 15; done_out pulses once after the 4th ack.
- Backpressure: toggle m_tready_in pseudo-randomly with len 64. Expected: no beat is lost or duplicated; data and tlast stay stable while stalled; the captured stream equals the buffer contents.
- Tail handling (len 40, FRAME_LEN 16, hop 10, frame 3 starts at address 30): with the macro defined, beats 10..15 of frame 3 are 0 and rd_addr_out ≤ 39. With the macro undefined, beats 10..15 read addresses 0..5.
- Degenerate lengths:
  - len 0: done_out pulses one cycle after start_in; m_tvalid_out never rises.
  - len 3 (< NUM_FRAMES): all four frames start at address 0.
- Ignored inputs: start_in while busy has no effect; an early frame_ack_in during STREAM is ignored; the sequencer waits for a fresh ack in WAIT_ACK.
- Reset mid-stream: drop rst_in_n at beat 7 of frame 1. Expected: all outputs go to 0 immediately; a new start_in replays from frame 0.
